// File: rtl/pixel_pkg.sv
// Shared widths, FSM state encoding and small helpers for the pixel batch engine.
// Included first so every other file can import it.
package pixel_pkg;

  localparam int ADDR_W  = 16;
  localparam int WORD_W  = 24;
  localparam int PIX_MAX = 20;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR_ACT1,
    WR_ACT2,
    WR_GAP
  } state_t;

  typedef logic [PIX_MAX-1:0][7:0] pix_arr_t;

  // Requests above the array depth run as a full batch of PIX_MAX pixels.
  function automatic logic [4:0] clamp_cnt(input logic [4:0] n);
    return (n > 5'(PIX_MAX)) ? 5'(PIX_MAX) : n;
  endfunction

  function automatic logic [WORD_W-1:0] gray_to_word(input logic [7:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational RGB888 to 8-bit grayscale: (R + 2G + B) >> 2.
// The 10-bit sum cannot overflow (max 1020).
module rgb_to_gray
  import pixel_pkg::*;
(
  input  logic [WORD_W-1:0] rgb,
  output logic [7:0]        gray
);

  logic [9:0] sum;

  assign sum  = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
  assign gray = 8'(sum >> 2);

endmodule

// File: rtl/pixel_controller.sv
// Batch engine: reads up to PIX_MAX RGB words from SRAM into grayscale data_out,
// then writes up to PIX_MAX grayscale bytes back as RGB words; 2 clk/read, 3 clk/write.
module pixel_controller
  import pixel_pkg::*;
(
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        address_read_offset,
  input  logic [ADDR_W-1:0]        address_write_offset,
  input  logic [4:0]               num_pix_read,
  input  logic [4:0]               num_pix_write,
  input  logic [PIX_MAX-1:0][7:0]  data_in,
  output logic [PIX_MAX-1:0][7:0]  data_out,
  output logic                     read_now,
  output logic [ADDR_W-1:0]        address,
  output logic [WORD_W-1:0]        w_data,
  input  logic [WORD_W-1:0]        r_data,
  output logic                     read_enable,
  output logic                     write_enable
);

  state_t            state;
  logic [4:0]        k;
  logic [4:0]        k_nxt;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] wr_off;
  logic [4:0]        rd_cnt;
  logic [4:0]        wr_cnt;
  logic [4:0]        rd_cnt_in;
  logic [4:0]        wr_cnt_in;
  logic [7:0]        gray;

  assign k_nxt     = k + 5'd1;
  assign rd_cnt_in = clamp_cnt(num_pix_read);
  assign wr_cnt_in = clamp_cnt(num_pix_write);

  rgb_to_gray u_gray (
    .rgb  (r_data),
    .gray (gray)
  );

  // Outputs are loaded on the edge that enters a state, so each state's
  // bus values are visible for that state's whole cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      k            <= '0;
      rd_off       <= '0;
      wr_off       <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      address      <= '0;
      w_data       <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      read_now     <= 1'b0;
      data_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          read_enable  <= 1'b0;
          write_enable <= 1'b0;
          read_now     <= 1'b0;
          k            <= '0;
          if (enable) begin
            rd_off <= address_read_offset;
            wr_off <= address_write_offset;
            rd_cnt <= rd_cnt_in;
            wr_cnt <= wr_cnt_in;
            if (rd_cnt_in != 5'd0) begin
              state       <= RD_ADDR;
              address     <= address_read_offset;
              read_enable <= 1'b1;
              read_now    <= 1'b1;
            end else if (wr_cnt_in != 5'd0) begin
              state        <= WR_ACT1;
              address      <= address_write_offset;
              w_data       <= gray_to_word(data_in[0]);
              write_enable <= 1'b1;
            end
          end
        end

        RD_ADDR: begin
          read_now <= 1'b0;
          state    <= RD_CAP;
        end

        // r_data is valid here; read_enable stays high across back-to-back reads.
        RD_CAP: begin
          data_out[k] <= gray;
          if (k_nxt < rd_cnt) begin
            k        <= k_nxt;
            address  <= rd_off + ADDR_W'(k_nxt);
            read_now <= 1'b1;
            state    <= RD_ADDR;
          end else begin
            k           <= '0;
            read_enable <= 1'b0;
            if (wr_cnt != 5'd0) begin
              address      <= wr_off;
              w_data       <= gray_to_word(data_in[0]);
              write_enable <= 1'b1;
              state        <= WR_ACT1;
            end else begin
              state <= IDLE;
            end
          end
        end

        WR_ACT1: begin
          state <= WR_ACT2;
        end

        WR_ACT2: begin
          write_enable <= 1'b0;
          state        <= WR_GAP;
        end

        // Address and data held while the strobe is low for one cycle.
        WR_GAP: begin
          if (k_nxt < wr_cnt) begin
            k            <= k_nxt;
            address      <= wr_off + ADDR_W'(k_nxt);
            w_data       <= gray_to_word(data_in[k_nxt]);
            write_enable <= 1'b1;
            state        <= WR_ACT1;
          end else begin
            k     <= '0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_controller.sv
// Directed bench for pixel_controller with a behavioural SRAM (fixed read
// contents, write log) and hand-computed expected values.
module tb_pixel_controller;

  logic              clk;
  logic              n_rst;
  logic              enable;
  logic [15:0]       address_read_offset;
  logic [15:0]       address_write_offset;
  logic [4:0]        num_pix_read;
  logic [4:0]        num_pix_write;
  logic [19:0][7:0]  data_in;
  logic [19:0][7:0]  data_out;
  logic              read_now;
  logic [15:0]       address;
  logic [23:0]       w_data;
  logic [23:0]       r_data;
  logic              read_enable;
  logic              write_enable;

  int vectors;
  int miscompares;

  pixel_controller dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .enable               (enable),
    .address_read_offset  (address_read_offset),
    .address_write_offset (address_write_offset),
    .num_pix_read         (num_pix_read),
    .num_pix_write        (num_pix_write),
    .data_in              (data_in),
    .data_out             (data_out),
    .read_now             (read_now),
    .address              (address),
    .w_data               (w_data),
    .r_data               (r_data),
    .read_enable          (read_enable),
    .write_enable         (write_enable)
  );

  initial clk = 1'b0;
  always #6 clk = ~clk;

  // Read-side SRAM contents as a fixed function of address.
  function automatic logic [23:0] sram_rd(input logic [15:0] a);
    logic [7:0] g;
    if (a >= 16'h0200 && a <= 16'h0213) begin
      g = 8'((a - 16'h0200) * 3);
      return {g, g, g};
    end
    case (a)
      16'h0000: return 24'hFF0000;
      16'h0001: return 24'h00FF00;
      16'h0002: return 24'h808080;
      16'h0012: return 24'hFFFFFF;
      16'h0013: return 24'h111111;
      16'hFFFF: return 24'h102030;
      default:  return 24'h000000;
    endcase
  endfunction

  assign r_data = read_enable ? sram_rd(address) : 24'h0;

  logic [23:0] wmem [0:65535];
  int          wcommit;

  initial wcommit = 0;
  always @(posedge clk) begin
    if (write_enable) begin
      wmem[address] <= w_data;
      wcommit       <= wcommit + 1;
    end
  end

  int          cyc;
  int          re_tot;
  int          we_tot;
  int          ovl_tot;
  int          rn_cyc  [$];
  logic [15:0] rn_addr [$];

  initial begin
    cyc = 0; re_tot = 0; we_tot = 0; ovl_tot = 0;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (read_enable)                 re_tot  = re_tot + 1;
    if (write_enable)                we_tot  = we_tot + 1;
    if (read_enable && write_enable) ovl_tot = ovl_tot + 1;
    if (read_now) begin
      rn_cyc.push_back(cyc);
      rn_addr.push_back(address);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one batch request for a single sampling edge; returns 1 ns after it.
  task automatic start(input logic [15:0] ro, input logic [15:0] wo,
                       input logic [4:0] nr, input logic [4:0] nw);
    address_read_offset  = ro;
    address_write_offset = wo;
    num_pix_read         = nr;
    num_pix_write        = nw;
    enable               = 1'b1;
    tick(1);
    enable               = 1'b0;
  endtask

  int re_b, we_b, ovl_b, rn_b, wc_b;

  task automatic snap();
    re_b  = re_tot;
    we_b  = we_tot;
    ovl_b = ovl_tot;
    rn_b  = rn_addr.size();
    wc_b  = wcommit;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    enable = 1'b0;
    address_read_offset = '0;
    address_write_offset = '0;
    num_pix_read = '0;
    num_pix_write = '0;
    data_in = '0;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("rst_address", 32'(address), 32'h0);
    check("rst_re_we_rn", {29'b0, read_enable, write_enable, read_now}, 32'h0);
    check("rst_data_out", 32'(data_out != '0), 32'h0);
    tick(2);
    n_rst = 1'b1;
    tick(1);

    // Read 3 pixels from address 0.
    snap();
    start(16'h0000, 16'h0000, 5'd3, 5'd0);
    check("rd3_first_rn", {31'b0, read_now}, 32'h1);
    check("rd3_first_addr", 32'(address), 32'h0);
    tick(8);
    check("rd3_rn_pulses", 32'(rn_addr.size() - rn_b), 32'd3);
    check("rd3_addr1", 32'(rn_addr[rn_b+1]), 32'h1);
    check("rd3_addr2", 32'(rn_addr[rn_b+2]), 32'h2);
    check("rd3_re_clocks", 32'(re_tot - re_b), 32'd6);
    check("rd3_pix0", 32'(data_out[0]), 32'h3F);
    check("rd3_pix1", 32'(data_out[1]), 32'h7F);
    check("rd3_pix2", 32'(data_out[2]), 32'h80);

    // Write 2 pixels at 0x0100.
    data_in[0] = 8'h12;
    data_in[1] = 8'hAB;
    snap();
    start(16'h0000, 16'h0100, 5'd0, 5'd2);
    tick(8);
    check("wr2_word0", 32'(wmem[16'h0100]), 32'h121212);
    check("wr2_word1", 32'(wmem[16'h0101]), 32'hABABAB);
    check("wr2_we_clocks", 32'(we_tot - we_b), 32'd4);
    check("wr2_no_reads", 32'(re_tot - re_b), 32'd0);
    check("wr2_keep_pix0", 32'(data_out[0]), 32'h3F);

    // Address wrap and count clamp: 25 requested, 20 performed.
    snap();
    start(16'hFFFF, 16'h0000, 5'd25, 5'd0);
    tick(45);
    check("wrap_rn_pulses", 32'(rn_addr.size() - rn_b), 32'd20);
    check("wrap_addr0", 32'(rn_addr[rn_b]), 32'hFFFF);
    check("wrap_addr1", 32'(rn_addr[rn_b+1]), 32'h0000);
    check("wrap_addr19", 32'(rn_addr[rn_b+19]), 32'h0012);
    check("wrap_pix0", 32'(data_out[0]), 32'h20);
    check("wrap_pix1", 32'(data_out[1]), 32'h3F);
    check("wrap_pix19", 32'(data_out[19]), 32'hFF);

    // Two back-to-back full batches with enable held; each batch is
    // 40 read + 60 write clocks, plus one IDLE clock before the restart.
    for (int i = 0; i < 20; i++) data_in[i] = 8'(i + 64);
    snap();
    address_read_offset  = 16'h0200;
    address_write_offset = 16'h0300;
    num_pix_read         = 5'd20;
    num_pix_write        = 5'd20;
    enable               = 1'b1;
    tick(150);
    enable               = 1'b0;
    tick(120);
    check("full_rn_pulses", 32'(rn_addr.size() - rn_b), 32'd40);
    check("full_b1_addr", 32'(rn_addr[rn_b]), 32'h0200);
    check("full_b2_addr", 32'(rn_addr[rn_b+20]), 32'h0200);
    check("full_read_pitch", 32'(rn_cyc[rn_b+1] - rn_cyc[rn_b]), 32'd2);
    check("full_batch_pitch", 32'(rn_cyc[rn_b+20] - rn_cyc[rn_b]), 32'd101);
    check("full_re_clocks", 32'(re_tot - re_b), 32'd80);
    check("full_we_clocks", 32'(we_tot - we_b), 32'd80);
    check("full_overlap", 32'(ovl_tot - ovl_b), 32'd0);
    check("full_wr_first", 32'(wmem[16'h0300]), 32'h404040);
    check("full_wr_last", 32'(wmem[16'h0313]), 32'h535353);
    check("full_pix5", 32'(data_out[5]), 32'h0F);
    check("full_pix19", 32'(data_out[19]), 32'h39);

    // Zero counts: no strobes at all.
    snap();
    address_read_offset  = 16'h0000;
    num_pix_read         = 5'd0;
    num_pix_write        = 5'd0;
    enable               = 1'b1;
    tick(5);
    enable               = 1'b0;
    tick(2);
    check("zero_strobes", 32'((re_tot - re_b) + (we_tot - we_b)), 32'd0);
    check("zero_rn", 32'(rn_addr.size() - rn_b), 32'd0);

    // Reset in the middle of a write: outputs clear at once, no write commits.
    data_in[0] = 8'h5A;
    snap();
    start(16'h0000, 16'h0400, 5'd0, 5'd2);
    check("abort_we_before", {31'b0, write_enable}, 32'h1);
    #2 n_rst = 1'b0;
    #1;
    check("abort_we", {31'b0, write_enable}, 32'h0);
    check("abort_address", 32'(address), 32'h0);
    check("abort_w_data", 32'(w_data), 32'h0);
    check("abort_re_rn", {30'b0, read_enable, read_now}, 32'h0);
    check("abort_data_out", 32'(data_out != '0), 32'h0);
    tick(2);
    check("abort_no_commit", 32'(wcommit - wc_b), 32'd0);
    n_rst = 1'b1;
    tick(1);
    start(16'h0002, 16'h0000, 5'd1, 5'd0);
    check("post_rst_rn", {31'b0, read_now}, 32'h1);
    check("post_rst_addr", 32'(address), 32'h2);
    tick(4);
    check("post_rst_pix0", 32'(data_out[0]), 32'h80);
    check("post_rst_pix1", 32'(data_out[1]), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pixel_controller.md
Name: pixel_controller

Overview:
- Pixel-batch engine between the edge-detector datapath and the off-chip 24-bit RGB SRAM. The SRAM is reached through the shared address, write-data and read-data bus plus the two enables.
- Each batch reads up to 20 RGB pixels from consecutive SRAM addresses and converts each one to 8-bit grayscale into data_out.
- It then writes up to 20 grayscale pixels from data_in back to consecutive addresses as RGB words.
- read_now marks each read access so a monitor can sample r_data.

Parameters:
- ADDR_W, 16, SRAM word-address width.
- WORD_W, 24, SRAM word width (R[23:16], G[15:8], B[7:0]).
- PIX_MAX, 20, maximum pixels per batch and depth of the data_in/data_out arrays.

Ports:
- clk  in  1  system clock, rising-edge active.
- n_rst  in  1  reset, asynchronous, active-low.
- enable  in  1  level; batch starts from IDLE while high.
- address_read_offset  in  ADDR_W  first read address.
- address_write_offset  in  ADDR_W  first write address.
- num_pix_read  in  5  pixels to read, 0..20.
- num_pix_write  in  5  pixels to write, 0..20.
- data_in  in  PIX_MAX x 8  grayscale pixels to write; element k goes to write_offset+k.
- data_out  out  PIX_MAX x 8  grayscale of pixel read from read_offset+k.
- read_now  out  1  high in the first cycle of each read access.
- address  out  ADDR_W  SRAM address.
- w_data  out  WORD_W  SRAM write data.
- r_data  in  WORD_W  SRAM read data; valid only while read_enable is high.
- read_enable  out  1  SRAM read strobe.
- write_enable  out  1  SRAM write strobe.

Behaviour:
- Reset (async, n_rst=0):
  - address=0, w_data=0, read_enable=0, write_enable=0, read_now=0, every data_out byte=0.
  - State goes to IDLE, counter k=0.
  - Reset mid-batch aborts the batch immediately; no partial write completes.
- States: IDLE, RD_ADDR, RD_CAP, WR_ACT1, WR_ACT2, WR_GAP.
- Registered outputs: all outputs are registered and change only on the rising clk edge.
- IDLE:
  - Enables low, read_now low.
  - If enable=1, latch the offsets, clamp the counts (values >20 are treated as 20), set k=0.
  - Then go to RD_ADDR if the read count >0, else WR_ACT1 if the write count >0, else stay in IDLE.
- RD_ADDR (1 cycle):
  - address=read_offset+k, read_enable=1, read_now=1.
- RD_CAP (1 cycle):
  - read_enable stays 1; read_now=0, so the falling edge of read_now occurs while r_data is valid.
  - At the end of the cycle, capture data_out[k] = (R + 2G + B) >> 2, using a 10-bit intermediate.
  - Then read_enable=0 and k increments.
  - Next state: RD_ADDR if k < read count, else k=0 and go to WR_ACT1 if the write count >0, else IDLE.
- Read latency: 2 clocks per pixel; no idle cycle between reads. The SRAM needs 10 ns access time against a 12 ns clock.
- WR_ACT1 / WR_ACT2 (2 cycles):
  - address=write_offset+k, w_data={data_in[k],data_in[k],data_in[k]}, write_enable=1.
- WR_GAP (1 cycle):
  - write_enable=0 while address and w_data are held.
  - Increment k; next state is WR_ACT1 if k < write count, else IDLE.
- Write latency: 3 clocks per pixel.
- Address arithmetic is modulo 2^16 (0xFFFF+1 wraps to 0x0000).
- read_enable and write_enable are never high in the same cycle.
- enable is sampled only in IDLE:
  - A batch always runs to completion even if enable drops.
  - If enable is still high on return to IDLE, a new batch starts with freshly latched offsets and counts.
- data_out entries not rewritten in a batch keep their previous values.
- Unused data_in entries are ignored.

Decomposition:
- Package pixel_pkg: ADDR_W, WORD_W, PIX_MAX, the state enum, and the pixel-array typedef (logic [PIX_MAX-1:0][7:0]).
- One combinational sub-module rgb_to_gray (24-bit in, 8-bit out, (R+2G+B)>>2).
- The FSM, counter and output registers live in pixel_controller.

Test Plan:
- Reset: assert n_rst=0 mid-batch -> all outputs 0 within the same timestep; state returns to IDLE.
- Read 3 pixels:
  - Stimulus: SRAM[0..2] = 0xFF0000, 0x00FF00, 0x808080; read_offset=0, num_pix_read=3, num_pix_write=0, enable pulse.
  - Response: three read_now pulses, addresses 0, 1, 2; data_out[0..2] = 0x3F, 0x7F, 0x80; 6 clocks total.
- Write 2 pixels:
  - Stimulus: data_in[0]=0x12, data_in[1]=0xAB; write_offset=0x0100, num_pix_write=2, num_pix_read=0.
  - Response: SRAM[0x0100]=0x121212, SRAM[0x0101]=0xABABAB; write_enable high 2 cycles per pixel; never overlaps read_enable.
- Wrap and clamp: read_offset=0xFFFF, num_pix_read=25 -> 20 reads on addresses 0xFFFF, 0x0000 .. 0x0012.
- Combined batch: read 20 pixels then write 20 pixels with enable held high -> 100 clocks per batch; second batch restarts at the read offset.
- Zero counts: both counts 0, enable=1 -> no strobes; controller remains in IDLE.
